// File: rtl/aes_pkg.sv
// Shared constants, FSM state encoding and key-word helper for AES-128
// key expansion.
package aes_pkg;
    localparam int BYTE   = 8;
    localparam int DWORD  = 32;
    localparam int LENGTH = 128;
    localparam int NR     = 10;

    typedef enum logic [1:0] {IDLE, EMIT, STEP, DONE} state_t;

    // Word i of a key, w0 in the most significant 32 bits.
    function automatic logic [DWORD-1:0] key_word(input logic [LENGTH-1:0] k,
                                                  input logic [1:0] i);
        return k[(3 - int'(i)) * DWORD +: DWORD];
    endfunction
endpackage

// File: rtl/aes_key_step.sv
// One combinational AES-128 key-expansion step.
//   i_key  : current round key, w0 in [127:96]
//   i_rcon : round constant word from the Rcon block
//   o_key  : next round key
module aes_key_step
    import aes_pkg::*;
(
    input  logic [LENGTH-1:0] i_key,
    input  logic [DWORD-1:0]  i_rcon,
    output logic [LENGTH-1:0] o_key
);
    logic [DWORD-1:0] w_w3;
    logic [DWORD-1:0] w_rot;
    logic [DWORD-1:0] w_sub;
    logic [DWORD-1:0] w_temp;
    logic [DWORD-1:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w3  = key_word(i_key, 2'd3);
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .i_byte (w_rot[g*BYTE +: BYTE]),
            .o_byte (w_sub[g*BYTE +: BYTE])
        );
    end

    assign w_temp = w_sub ^ i_rcon;
    assign w_n0   = key_word(i_key, 2'd0) ^ w_temp;
    assign w_n1   = key_word(i_key, 2'd1) ^ w_n0;
    assign w_n2   = key_word(i_key, 2'd2) ^ w_n1;
    assign w_n3   = w_w3 ^ w_n2;
    assign o_key  = {w_n0, w_n1, w_n2, w_n3};
endmodule

// File: rtl/aes_rcon.sv
// AES round constant lookup.
//   i_round : expansion round 0..9
//   o_rcon  : Rcon word, constant byte in bits [31:24]
module aes_rcon (
    input  logic [3:0]  i_round,
    output logic [31:0] o_rcon
);
    always_comb begin
        o_rcon = 32'h0;
        case (i_round)
            4'd0: o_rcon = 32'h01000000;
            4'd1: o_rcon = 32'h02000000;
            4'd2: o_rcon = 32'h04000000;
            4'd3: o_rcon = 32'h08000000;
            4'd4: o_rcon = 32'h10000000;
            4'd5: o_rcon = 32'h20000000;
            4'd6: o_rcon = 32'h40000000;
            4'd7: o_rcon = 32'h80000000;
            4'd8: o_rcon = 32'h1b000000;
            4'd9: o_rcon = 32'h36000000;
            default: o_rcon = 32'h0;
        endcase
    end
endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte.
//   i_byte : input byte
//   o_byte : substituted byte
// Computed as the GF(2^8) inverse (x^254) followed by the affine transform.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as required.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    logic [7:0] w_inv;

    assign w_inv  = ginv(i_byte);
    assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: captures a cipher key on start and
// streams round keys 0..NR over a valid/ready interface.
//   clk, rst_n         : clock, async active-low reset
//   start, cipher_key  : begin expansion with this key (IDLE only)
//   abort              : return to IDLE next cycle, highest priority
//   busy               : expansion in progress (EMIT/STEP)
//   rk_valid/ready     : round-key stream handshake
//   rk_data, rk_index  : current round key and its index
//   done               : one-cycle pulse after key NR is accepted
module aes_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LENGTH-1:0] cipher_key,
    input  logic              abort,
    output logic              busy,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [LENGTH-1:0] rk_data,
    output logic [3:0]        rk_index,
    output logic              done
);
    state_t            r_state;
    state_t            w_next;
    logic [LENGTH-1:0] r_key;
    logic [3:0]        r_idx;
    logic [3:0]        w_rcon_round;
    logic [DWORD-1:0]  w_rcon;
    logic [LENGTH-1:0] w_step_key;

    // Rcon only sees a non-zero round during STEP, where r_idx <= NR-1.
    assign w_rcon_round = (r_state == STEP) ? r_idx : 4'd0;

    aes_rcon u_rcon (
        .i_round (w_rcon_round),
        .o_rcon  (w_rcon)
    );

    aes_key_step u_step (
        .i_key  (r_key),
        .i_rcon (w_rcon),
        .o_key  (w_step_key)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start && !abort) w_next = EMIT;
            EMIT: begin
                if (abort)
                    w_next = IDLE;
                else if (rk_ready)
                    w_next = (r_idx == 4'(NR)) ? DONE : STEP;
            end
            STEP: w_next = abort ? IDLE : EMIT;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_key   <= '0;
            r_idx   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == EMIT)
                r_key <= cipher_key;
            else if (r_state == STEP && w_next == EMIT)
                r_key <= w_step_key;
            // Every path back to IDLE (abort, completion) clears the index.
            if (w_next == IDLE)
                r_idx <= 4'd0;
            else if (r_state == STEP)
                r_idx <= r_idx + 4'd1;
        end
    end

    assign busy     = (r_state == EMIT) || (r_state == STEP);
    assign rk_valid = (r_state == EMIT);
    assign done     = (r_state == DONE);
    assign rk_index = r_idx;
    // The key register may hold stale data after abort; mask it in IDLE.
    assign rk_data  = (r_state == IDLE) ? '0 : r_key;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
module tb_aes_key_sched_ctrl;
    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] cipher_key;
    logic         abort;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         done;

    int nvec = 0;
    int nerr = 0;

    logic [127:0] fips_rk [0:10];
    logic [127:0] fips_key;

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cipher_key (cipher_key),
        .abort      (abort),
        .busy       (busy),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_data    (rk_data),
        .rk_index   (rk_index),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_key(input bit full, input logic [3:0] idx);
        if (full) return fips_rk[idx];
        if (idx == 4'd1)  return 128'h62636363626363636263636362636363;
        if (idx == 4'd10) return 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        return 128'h0;
    endfunction

    // Drives one expansion and checks every emitted key. full=1 uses the
    // FIPS-197 table; otherwise the all-zero key with indices 0, 1, 10 known.
    // Returns the cycle count from the accepting edge and keys accepted.
    task automatic run(input logic [127:0] key, input bit full, input int stall_at,
                       input int restart_at, input int abort_at,
                       output int cyc, output int nk);
        int stalls;
        stalls = 0;
        nk = 0;
        cipher_key = key;
        start = 1'b1;
        abort = 1'b0;
        rk_ready = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            rk_ready = 1'b1;
            start = 1'b0;
            abort = 1'b0;
            if (rk_valid) begin
                chk("idx_range", {127'h0, rk_index > 4'd10}, 128'h0);
                if (int'(rk_index) == stall_at && stalls < 5) begin
                    rk_ready = 1'b0;
                    stalls++;
                    chk("stall_idx", {124'h0, rk_index}, 128'(stall_at));
                end
                if (rk_ready) nk++;
                if (full || rk_index == 4'd0 || rk_index == 4'd1 || rk_index == 4'd10)
                    chk($sformatf("rk%0d", rk_index), rk_data, exp_key(full, rk_index));
                if (int'(rk_index) == restart_at) begin
                    start = 1'b1;
                    cipher_key = ~key;
                end
                if (int'(rk_index) == abort_at) begin
                    abort = 1'b1;
                    tick();
                    cyc++;
                    abort = 1'b0;
                    chk("abort_valid", {127'h0, rk_valid}, 128'h0);
                    chk("abort_busy",  {127'h0, busy},     128'h0);
                    chk("abort_idx",   {124'h0, rk_index}, 128'h0);
                    chk("abort_data",  rk_data,            128'h0);
                    chk("abort_done",  {127'h0, done},     128'h0);
                    return;
                end
            end
            tick();
            cyc++;
        end
        if (cyc >= 200) chk("timeout", 128'(cyc), 128'h0);
    endtask

    task automatic check_done(input string tag, input int cyc, input int nk, input int exp_cyc);
        chk({tag, "_done"},  {127'h0, done}, 128'h1);
        chk({tag, "_busy"},  {127'h0, busy}, 128'h0);
        chk({tag, "_cyc"},   128'(cyc),      128'(exp_cyc));
        chk({tag, "_nkeys"}, 128'(nk),       128'd11);
        tick();
        chk({tag, "_pulse"}, {127'h0, done}, 128'h0);
        chk({tag, "_idx0"},  {124'h0, rk_index}, 128'h0);
    endtask

    initial begin
        int cyc;
        int nk;
        fips_key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[0]  = fips_key;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        rk_ready = 1'b0;
        cipher_key = 128'h0;
        tick();
        tick();
        chk("rst_busy",  {127'h0, busy},     128'h0);
        chk("rst_valid", {127'h0, rk_valid}, 128'h0);
        chk("rst_data",  rk_data,            128'h0);
        chk("rst_idx",   {124'h0, rk_index}, 128'h0);
        chk("rst_done",  {127'h0, done},     128'h0);
        rst_n = 1'b1;
        tick();

        // Back-to-back FIPS-197 sequence.
        run(fips_key, 1'b1, -1, -1, -1, cyc, nk);
        check_done("fips", cyc, nk, 22);

        // Five-cycle stall at index 3.
        run(fips_key, 1'b1, 3, -1, -1, cyc, nk);
        check_done("stall", cyc, nk, 27);

        // start re-pulsed at index 4 must not restart.
        run(fips_key, 1'b1, -1, 4, -1, cyc, nk);
        check_done("restart", cyc, nk, 22);

        // Abort on the index 6 handshake, then no done pulse.
        run(fips_key, 1'b1, -1, -1, 6, cyc, nk);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_nodone", {127'h0, done | busy}, 128'h0);
        end
        run(fips_key, 1'b1, -1, -1, -1, cyc, nk);
        check_done("post_abort", cyc, nk, 22);

        // Asynchronous reset during STEP.
        cipher_key = fips_key;
        start = 1'b1;
        rk_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("in_step", {126'h0, busy, rk_valid}, 128'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",  {127'h0, busy},     128'h0);
        chk("arst_valid", {127'h0, rk_valid}, 128'h0);
        chk("arst_data",  rk_data,            128'h0);
        chk("arst_idx",   {124'h0, rk_index}, 128'h0);
        chk("arst_done",  {127'h0, done},     128'h0);
        #2 rst_n = 1'b1;
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_hold", {126'h0, busy, rk_valid}, 128'h0);
        end
        start = 1'b1;
        tick();
        chk("start_abort", {126'h0, busy, rk_valid}, 128'h0);
        start = 1'b0;
        abort = 1'b0;
        tick();
        chk("still_idle", {126'h0, busy, rk_valid}, 128'h0);

        // All-zero key.
        run(128'h0, 1'b0, -1, -1, -1, cyc, nk);
        check_done("zero", cyc, nk, 22);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
